// File: rtl/nco_sweep_ctrl.sv
// Linear-chirp sweep controller for the NCO: steps the phase increment from a start value
// by a signed delta, holding each value for a programmable dwell, single-shot or continuous.
module nco_sweep_ctrl #(
  parameter int PHW   = 32,
  parameter int STEPW = 16,
  parameter int DWW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [PHW-1:0]   phi_start,
  input  logic [PHW-1:0]   phi_step,
  input  logic [STEPW-1:0] num_steps,
  input  logic [DWW-1:0]   dwell,
  output logic [PHW-1:0]   phi_inc_o,
  output logic             clken_o,
  output logic             sweep_active,
  output logic             step_strobe,
  output logic             sweep_done,
  output logic [1:0]       dbg_state_o
);

  // Control inputs are level-sampled on each rising edge; there is no handshake,
  // abort wins over start and continuous, and start is honoured only in IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [PHW-1:0]   step_q;
  logic [STEPW-1:0] last_step_q;
  logic [DWW-1:0]   last_dwell_q;
  logic [DWW-1:0]   dwell_cnt_q;
  logic [STEPW-1:0] step_cnt_q;

  logic [STEPW-1:0] last_step_d;
  logic [DWW-1:0]   last_dwell_d;
  logic             launch_d;
  logic             cfg_ok_d;

  // Terminal counts are stored pre-decremented so RUN compares counters directly.
  always_comb begin
    last_step_d  = num_steps - STEPW'(1);
    last_dwell_d = (dwell == '0) ? '0 : (dwell - DWW'(1));
    cfg_ok_d     = (num_steps != '0);
    launch_d     = 1'b0;
    if (state_q == S_IDLE) launch_d = start;
    if (state_q == S_DONE) launch_d = continuous;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      last_step_q  <= '0;
      last_dwell_q <= '0;
      dwell_cnt_q  <= '0;
      step_cnt_q   <= '0;
      phi_inc_o    <= '0;
      clken_o      <= 1'b0;
      sweep_active <= 1'b0;
      step_strobe  <= 1'b0;
      sweep_done   <= 1'b0;
    end else if (abort) begin
      // phi_inc_o deliberately holds so the NCO parks on its last frequency.
      state_q      <= S_IDLE;
      clken_o      <= 1'b0;
      sweep_active <= 1'b0;
      step_strobe  <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      sweep_done  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (launch_d && cfg_ok_d) begin
            state_q      <= S_RUN;
            step_q       <= phi_step;
            last_step_q  <= last_step_d;
            last_dwell_q <= last_dwell_d;
            dwell_cnt_q  <= '0;
            step_cnt_q   <= '0;
            phi_inc_o    <= phi_start;
            clken_o      <= 1'b1;
            sweep_active <= 1'b1;
          end else if (launch_d) begin
            // Zero-length sweep completes immediately without touching phi_inc_o.
            state_q      <= S_DONE;
            sweep_done   <= 1'b1;
            clken_o      <= 1'b0;
            sweep_active <= 1'b0;
          end else begin
            state_q      <= S_IDLE;
            clken_o      <= 1'b0;
            sweep_active <= 1'b0;
          end
        end
        S_RUN: begin
          if (dwell_cnt_q == last_dwell_q) begin
            dwell_cnt_q <= '0;
            if (step_cnt_q == last_step_q) begin
              state_q      <= S_DONE;
              sweep_done   <= 1'b1;
              clken_o      <= 1'b0;
              sweep_active <= 1'b0;
            end else begin
              phi_inc_o   <= phi_inc_o + step_q;
              step_cnt_q  <= step_cnt_q + STEPW'(1);
              step_strobe <= 1'b1;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + DWW'(1);
          end
        end
        default: begin
          state_q      <= S_IDLE;
          clken_o      <= 1'b0;
          sweep_active <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: a sweep-schedule model checked every cycle,
// plus directed scenarios pinned with hand-computed literal values.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] phi_start = '0;
  logic [31:0] phi_step = '0;
  logic [15:0] num_steps = '0;
  logic [15:0] dwell = '0;
  logic [31:0] phi_inc_o;
  logic        clken_o;
  logic        sweep_active;
  logic        step_strobe;
  logic        sweep_done;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  logic [31:0] t1_phi [4] = '{32'h01A36E2F, 32'h01B36E2F, 32'h01C36E2F, 32'h01D36E2F};

  nco_sweep_ctrl #(.PHW(32), .STEPW(16), .DWW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .phi_start(phi_start), .phi_step(phi_step), .num_steps(num_steps), .dwell(dwell),
    .phi_inc_o(phi_inc_o), .clken_o(clken_o), .sweep_active(sweep_active),
    .step_strobe(step_strobe), .sweep_done(sweep_done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Model: 0 = idle, 1 = sweeping, 2 = done cycle. While sweeping, m_k is the
  // elapsed cycle index and outputs follow from it arithmetically.
  int          m_mode = 0;
  longint      m_k = 0;
  longint      m_n = 0;
  longint      m_d = 1;
  logic [31:0] m_p0 = '0;
  logic [31:0] m_step = '0;
  logic [31:0] m_hold = '0;

  function automatic logic [31:0] mdl_phi();
    if (m_mode == 1) return m_p0 + m_step * 32'(m_k / m_d);
    return m_hold;
  endfunction

  task automatic mdl_launch();
    m_p0   = phi_start;
    m_step = phi_step;
    m_n    = longint'(num_steps);
    m_d    = (dwell == 16'd0) ? 1 : longint'(dwell);
    m_k    = 0;
    m_mode = (m_n == 0) ? 2 : 1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0;
      m_hold = '0;
      m_k    = 0;
    end else if (abort) begin
      if (m_mode == 1) m_hold = mdl_phi();
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start) mdl_launch();
        1: begin
          if (m_k + 1 == m_n * m_d) begin
            m_hold = m_p0 + m_step * 32'(m_n - 1);
            m_mode = 2;
          end else begin
            m_k++;
          end
        end
        default: if (continuous) mdl_launch(); else m_mode = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_phi_inc", phi_inc_o, mdl_phi());
      chk("mdl_clken", clken_o, m_mode == 1);
      chk("mdl_active", sweep_active, m_mode == 1);
      chk("mdl_strobe", step_strobe, (m_mode == 1) && (m_k != 0) && (m_k % m_d == 0));
      chk("mdl_done", sweep_done, m_mode == 2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg(input logic [31:0] p0, input logic [31:0] st, input logic [15:0] n,
                     input logic [15:0] d);
    phi_start = p0;
    phi_step  = st;
    num_steps = n;
    dwell     = d;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    cmp_en = 1'b1;
    chk("rst_phi", phi_inc_o, 32'h0);
    chk("rst_clken", clken_o, 1'b0);
    chk("rst_done", sweep_done, 1'b0);
    reset = 1'b0;
    tick();

    // Basic 4-step sweep, 3 cycles per increment.
    cfg(32'h01A36E2F, 32'h00100000, 16'd4, 16'd3);
    kick();
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        chk("t1_phi", phi_inc_o, t1_phi[(c - 1) / 3]);
        chk("t1_clken", clken_o, 1'b1);
        chk("t1_strobe", step_strobe, (c == 4) || (c == 7) || (c == 10));
      end else begin
        chk("t1_done", sweep_done, 1'b1);
        chk("t1_clken_off", clken_o, 1'b0);
      end
      tick();
    end
    chk("t1_done_1cyc", sweep_done, 1'b0);
    tick();

    // Negative step with wrap through zero.
    cfg(32'h00000010, 32'hFFFFFFF0, 16'd3, 16'd1);
    kick();
    chk("t2_phi0", phi_inc_o, 32'h00000010);
    tick();
    chk("t2_phi1", phi_inc_o, 32'h00000000);
    tick();
    chk("t2_phi2", phi_inc_o, 32'hFFFFFFF0);
    tick();
    chk("t2_done", sweep_done, 1'b1);
    tick();
    chk("t2_hold", phi_inc_o, 32'hFFFFFFF0);
    tick();

    // dwell=0 behaves as 1; then a zero-length sweep.
    cfg(32'h00000100, 32'h00000001, 16'd2, 16'd0);
    kick();
    chk("t3_phi0", phi_inc_o, 32'h00000100);
    tick();
    chk("t3_phi1", phi_inc_o, 32'h00000101);
    chk("t3_strobe", step_strobe, 1'b1);
    tick();
    chk("t3_done", sweep_done, 1'b1);
    tick();
    cfg(32'h0BADF00D, 32'h00000001, 16'd0, 16'd5);
    kick();
    chk("t3_n0_done", sweep_done, 1'b1);
    chk("t3_n0_clken", clken_o, 1'b0);
    chk("t3_n0_phi", phi_inc_o, 32'h00000101);
    tick();
    chk("t3_n0_done_off", sweep_done, 1'b0);
    tick();

    // Continuous mode: 5-cycle period, stop after clearing continuous.
    cfg(32'h00002000, 32'h00000010, 16'd2, 16'd2);
    continuous = 1'b1;
    kick();
    for (int c = 1; c <= 16; c++) begin
      if (c == 5 || c == 10 || c == 15) chk("t4_done", sweep_done, 1'b1);
      if (c == 6 || c == 11) begin
        chk("t4_reload", phi_inc_o, 32'h00002000);
        chk("t4_rerun", clken_o, 1'b1);
      end
      if (c == 16) chk("t4_stopped", clken_o, 1'b0);
      if (c == 11) continuous = 1'b0;
      tick();
    end

    // Abort during the second increment; then start+abort together.
    cfg(32'h01A36E2F, 32'h00100000, 16'd4, 16'd3);
    kick();
    repeat (4) tick();
    chk("t5_phi_pre", phi_inc_o, 32'h01B36E2F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_clken", clken_o, 1'b0);
    chk("t5_active", sweep_active, 1'b0);
    chk("t5_phi_hold", phi_inc_o, 32'h01B36E2F);
    for (int i = 0; i < 14; i++) begin
      chk("t5_nodone", sweep_done, 1'b0);
      tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_sa_clken", clken_o, 1'b0);
    tick();
    chk("t5_sa_idle", sweep_active, 1'b0);
    tick();

    // Reset mid-sweep.
    kick();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_phi", phi_inc_o, 32'h0);
    chk("t6_rst_clken", clken_o, 1'b0);
    chk("t6_rst_active", sweep_active, 1'b0);
    chk("t6_rst_strobe", step_strobe, 1'b0);
    chk("t6_rst_done", sweep_done, 1'b0);
    tick();

    // Start pulse and config changes during RUN are ignored.
    kick();
    for (int c = 1; c <= 13; c++) begin
      if (c == 2) begin
        start = 1'b1;
        cfg(32'hDEADBEEF, 32'h00000001, 16'd1, 16'd7);
      end
      if (c == 3) start = 1'b0;
      if (c == 12) chk("t6_phi_last", phi_inc_o, 32'h01D36E2F);
      if (c == 13) chk("t6_done", sweep_done, 1'b1);
      tick();
    end
    repeat (3) tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
